jtag_debug_ocimem: RTL and testbench
====================================

Name: jtag_debug_ocimem

Overview:
- Debug monitor memory stage directly downstream of the JTAG debug module's system-clock-side action decoder.
- Consumes the jdo[37:0] payload and the single-cycle take_*_ocimem_* pulses, executes word reads and writes into an on-chip debug RAM, and returns MonDReg, monitor_ready and monitor_error to the JTAG shift logic.
- Also exposes the same RAM to the CPU through an Avalon-MM slave port. A single-port RAM is arbitrated between the JTAG side and the CPU side, with JTAG having priority.

Parameters:
ADDR_W, 8, word-address width; RAM depth is 2**ADDR_W words of 32 bits.
JDO_ADDR_LSB, 17, bit position of the address field in jdo. The field is jdo[JDO_ADDR_LSB+ADDR_W : JDO_ADDR_LSB]; its top bit is the out-of-range flag.

Ports:
clk  in  1  system clock; the only clock in this block.
reset  in  1  synchronous, active-high reset.
jdo  in  38  JTAG data-out payload.
take_action_ocimem_a  in  1  1-cycle pulse: load address and control.
take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at the current address.
take_no_action_ocimem_a  in  1  1-cycle pulse: read the current address.
MonDReg  out  32  last JTAG read data.
monitor_ready  out  1  MonDReg valid.
monitor_error  out  1  sticky error flag.
avs_address  in  ADDR_W  CPU word address.
avs_read  in  1  CPU read request.
avs_write  in  1  CPU write request.
avs_writedata  in  32  CPU write data.
avs_byteenable  in  4  CPU byte lanes.
avs_readdata  out  32  CPU read data.
avs_waitrequest  out  1  CPU stall.

Behaviour:
- Reset (synchronous, active-high, takes effect on the next clk edge):
  - MonDReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0.
  - Current address=0, auto-increment off, pending JTAG request cleared, FSM returns to IDLE.
  - RAM contents are preserved; any in-flight operation is abandoned.
- Address-load pulse (take_action_ocimem_a):
  - Current address is loaded from the jdo address field.
  - jdo[36] sets auto-increment; jdo[37]=1 clears monitor_error; monitor_ready is cleared.
  - If jdo[35]=1, a read is queued for the loaded address.
  - If the out-of-range flag bit is 1: monitor_error is set and no RAM access occurs. Subsequent write and read pulses are ignored until a valid address is loaded.
- Write pulse (take_action_ocimem_b): queues a full 32-bit write of jdo[34:3].
- Read pulse (take_no_action_ocimem_a): queues a read and clears monitor_ready.
- Pending register:
  - Holds one JTAG request.
  - A new queued request while one is still pending sets monitor_error and is dropped.
  - The address-load part of the address-load pulse is always applied.
- FSM states: IDLE, JRD, CRD.
  - IDLE with a JTAG request pending: JTAG is granted the RAM this cycle.
    - Write: RAM written this cycle, pending cleared, stays IDLE.
    - Read: RAM read issued, go to JRD.
  - IDLE, nothing pending, avs_write=1: CPU write granted with byte enables; avs_waitrequest=0 in the same cycle.
  - IDLE, nothing pending, avs_read=1: RAM read issued, go to CRD.
  - JRD: MonDReg takes the RAM data, monitor_ready=1 on the next edge, pending cleared, return to IDLE.
  - CRD: avs_readdata takes the RAM data and avs_waitrequest=0 this cycle; return to IDLE.
- Latencies with no contention:
  - CPU read: 2 cycles.
  - CPU write: 1 cycle.
  - JTAG read: monitor_ready rises 2 edges after the pulse edge.
- avs_waitrequest = (avs_read|avs_write) & !ack. It is combinational from state and the pending flag, and is low when there is no request.
- A JTAG request arriving while the FSM is in CRD is serviced on the following IDLE cycle; the CPU read is never aborted.
- Auto-increment:
  - After each completed JTAG read or write, address = address+1, modulo 2**ADDR_W.
  - 2**ADDR_W-1 wraps to 0 with no error.
- Simultaneous JTAG pulses in one cycle: priority is address-load, then write, then read. Lower-priority pulses are dropped and set monitor_error.
- CPU reads and writes never touch monitor_ready or monitor_error.

Test Plan:
- Reset then idle: MonDReg=0, monitor_ready=0, monitor_error=0, avs_waitrequest=0.
- JTAG write then read-back:
  - Load address 0x10 with auto-increment; write 0xDEADBEEF; write 0x12345678.
  - Reload address 0x10 with jdo[35]=1: MonDReg=0xDEADBEEF, monitor_ready high exactly 2 cycles after the pulse.
  - Read pulse: MonDReg=0x12345678.
- Wrap:
  - Load address 0xFF with auto-increment; write 0xA5A5A5A5 (lands at 0xFF); write 0x5A5A5A5A lands at 0x00.
  - CPU read of address 0x00 returns 0x5A5A5A5A after 2 cycles.
- Contention:
  - Assert a CPU read of 0x20 in the same cycle as a JTAG write pulse to 0x20 (0x11112222).
  - JTAG write takes the cycle; avs_waitrequest stays high for 3 cycles total; avs_readdata=0x11112222.
- Byte enables: CPU write 0xFFFFFFFF with byteenable=4'b0101 over 0x00000000; JTAG read returns 0x00FF00FF.
- Errors and reset mid-operation:
  - Address field with the out-of-range bit set: monitor_error=1 and a following write leaves the RAM unchanged.
  - Load with jdo[37]=1: monitor_error clears.
  - Reset asserted in JRD: monitor_ready remains 0 and the FSM is in IDLE on the next cycle.

Source files
------------

// File: rtl/jtag_debug_ocimem_if.sv
// Avalon-MM slave bundle through which the CPU reaches the debug RAM.
//   avs_address     word address (ADDR_W bits), from the CPU
//   avs_read        read request, held until avs_waitrequest is low
//   avs_write       write request, held until avs_waitrequest is low
//   avs_writedata   32-bit write data
//   avs_byteenable  byte lanes for writes
//   avs_readdata    read data, valid in the cycle avs_waitrequest drops on a read
//   avs_waitrequest stall; low when there is no request
// Handshake: a request is held stable by the master and completes in the
// cycle where it is asserted and avs_waitrequest is low.
interface jtag_debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/jtag_debug_ocimem.sv
// JTAG debug monitor memory stage. Executes JTAG word reads/writes into an
// on-chip debug RAM and shares the same single-port RAM with the CPU through
// an Avalon-MM slave; JTAG has priority.
// Ports:
//   clk, reset               system clock, synchronous active-high reset
//   jdo[37:0]                JTAG payload: [37] clear error, [36] auto-inc,
//                            [35] read-after-load, [34:3] write data,
//                            address field at JDO_ADDR_LSB (top bit = out of range)
//   take_action_ocimem_a     load address/control
//   take_action_ocimem_b     write jdo[34:3] at current address
//   take_no_action_ocimem_a  read current address
//   MonDReg, monitor_ready   last JTAG read data and its valid flag
//   monitor_error            sticky error flag
//   avs                      CPU Avalon-MM slave port
//   dbg_state                FSM state (0 IDLE, 1 JRD, 2 CRD)
module jtag_debug_ocimem #(
  parameter int ADDR_W       = 8,
  parameter int JDO_ADDR_LSB = 17
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [37:0]                jdo,
  input  logic                       take_action_ocimem_a,
  input  logic                       take_action_ocimem_b,
  input  logic                       take_no_action_ocimem_a,
  output logic [31:0]                MonDReg,
  output logic                       monitor_ready,
  output logic                       monitor_error,
  jtag_debug_ocimem_if.slave         avs,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JRD  = 2'd1,
    CRD  = 2'd2
  } state_t;

  state_t state;

  logic [31:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] cur_addr;
  logic              addr_bad;
  logic              auto_inc;
  logic              pend_valid;
  logic              pend_write;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_data;
  logic [31:0]       jtag_q;
  logic [31:0]       cpu_rdata;

  logic [ADDR_W:0]   jdo_addr;
  logic              jdo_bad;
  assign jdo_addr = jdo[JDO_ADDR_LSB+ADDR_W -: ADDR_W+1];
  assign jdo_bad  = jdo_addr[ADDR_W];

  logic unused_jdo;
  assign unused_jdo = ^jdo[2:0];

  // Arbitration. Any JTAG pulse in flight also holds the CPU off for that
  // cycle, so a CPU access that coincides with a JTAG pulse sees the JTAG
  // effect (the request becomes pending on the next edge).
  logic jtag_in, jtag_grant, jtag_rd_grant, jtag_done;
  logic cpu_free, cpu_wr_grant, cpu_rd_grant, ack;

  assign jtag_in       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign jtag_grant    = (state == IDLE) && pend_valid && !reset;
  assign jtag_rd_grant = jtag_grant && !pend_write;
  assign jtag_done     = (jtag_grant && pend_write) || (state == JRD);
  assign cpu_free      = (state == IDLE) && !pend_valid && !jtag_in && !reset;
  assign cpu_wr_grant  = cpu_free && avs.avs_write;
  assign cpu_rd_grant  = cpu_free && !avs.avs_write && avs.avs_read;
  assign ack           = cpu_wr_grant || (state == CRD);

  assign avs.avs_waitrequest = (avs.avs_read | avs.avs_write) & ~ack;
  assign avs.avs_readdata    = cpu_rdata;
  assign dbg_state           = state;

  // Address the next queued b/read pulse uses: follows a same-cycle increment.
  logic [ADDR_W-1:0] addr_next;
  assign addr_next = (jtag_done && auto_inc) ? ADDR_W'(cur_addr + 1'b1) : cur_addr;

  // Pulse decode: priority load > write > read; losers are flagged.
  logic              q_req, q_write, q_conflict, pend_free;
  logic [ADDR_W-1:0] q_addr;
  always_comb begin
    q_req      = 1'b0;
    q_write    = 1'b0;
    q_conflict = 1'b0;
    q_addr     = addr_next;
    if (take_action_ocimem_a) begin
      q_conflict = take_action_ocimem_b | take_no_action_ocimem_a;
      if (!jdo_bad && jdo[35]) begin
        q_req  = 1'b1;
        q_addr = jdo_addr[ADDR_W-1:0];
      end
    end else if (take_action_ocimem_b) begin
      q_conflict = take_no_action_ocimem_a;
      q_req      = !addr_bad;
      q_write    = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      q_req = !addr_bad;
    end
  end

  // A slot being retired this cycle can be refilled on the same edge.
  assign pend_free = !pend_valid || jtag_done;

  // RAM port mux.
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  assign ram_addr  = jtag_grant ? pend_addr : avs.avs_address;
  assign ram_we    = (jtag_grant && pend_write) || cpu_wr_grant;
  assign ram_be    = jtag_grant ? 4'hF : avs.avs_byteenable;
  assign ram_wdata = jtag_grant ? pend_data : avs.avs_writedata;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Read data lands directly in the requester's register so the CPU sees
  // valid avs_readdata in the CRD (acknowledge) cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= '0;
      jtag_q    <= '0;
    end else begin
      if (cpu_rd_grant)  cpu_rdata <= mem[ram_addr];
      if (jtag_rd_grant) jtag_q    <= mem[ram_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      cur_addr      <= '0;
      addr_bad      <= 1'b0;
      auto_inc      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
    end else begin
      if (jtag_done) pend_valid <= 1'b0;
      if (q_req && pend_free) begin
        pend_valid <= 1'b1;
        pend_write <= q_write;
        pend_addr  <= q_addr;
        pend_data  <= jdo[34:3];
      end

      if (take_action_ocimem_a) begin
        cur_addr <= jdo_addr[ADDR_W-1:0];
        addr_bad <= jdo_bad;
        auto_inc <= jdo[36];
      end else if (jtag_done && auto_inc) begin
        cur_addr <= ADDR_W'(cur_addr + 1'b1);
      end

      if ((take_action_ocimem_a && jdo_bad) || (q_req && !pend_free) || q_conflict)
        monitor_error <= 1'b1;
      else if (take_action_ocimem_a && jdo[37])
        monitor_error <= 1'b0;

      if (state == JRD) begin
        MonDReg       <= jtag_q;
        monitor_ready <= 1'b1;
      end
      if (take_action_ocimem_a || take_no_action_ocimem_a) monitor_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (jtag_rd_grant)     state <= JRD;
          else if (cpu_rd_grant) state <= CRD;
        end
        JRD:     state <= IDLE;
        CRD:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_debug_ocimem.sv
module tb_jtag_debug_ocimem;
  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_no_a;
  logic [31:0] mon_dreg;
  logic        mon_ready, mon_error;
  logic [1:0]  dbg_state;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  jtag_debug_ocimem_if #(.ADDR_W(8)) avs ();

  jtag_debug_ocimem #(.ADDR_W(8), .JDO_ADDR_LSB(17)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_no_a),
    .MonDReg                 (mon_dreg),
    .monitor_ready           (mon_ready),
    .monitor_error           (mon_error),
    .avs                     (avs),
    .dbg_state               (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_load(input logic [8:0] a, input logic inc, input logic rd, input logic clr);
    jdo = '0;
    jdo[37] = clr;
    jdo[36] = inc;
    jdo[35] = rd;
    jdo[25:17] = a;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  // Pulse then one service edge.
  task automatic jtag_write(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    tick();
  endtask

  task automatic jtag_read_pulse();
    take_no_a = 1'b1;
    tick();
    take_no_a = 1'b0;
  endtask

  // Called right after the pulse edge: ready must be low after one edge and
  // high after the second.
  task automatic jtag_result(input string tag, input logic [31:0] exp);
    tick();
    check({tag, "_ready_early"}, {31'd0, mon_ready}, 32'd0);
    tick();
    check({tag, "_ready"}, {31'd0, mon_ready}, 32'd1);
    check({tag, "_data"}, mon_dreg, exp);
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a, input logic [31:0] exp,
                          input int exp_waits, input logic with_jtag_wr, input logic [31:0] jd);
    int   waits;
    logic done;
    logic [31:0] data;
    waits = 0;
    done  = 1'b0;
    data  = '0;
    avs.avs_address = a;
    avs.avs_read    = 1'b1;
    if (with_jtag_wr) begin
      jdo = '0;
      jdo[34:3] = jd;
      take_b = 1'b1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      #3;
      if (!avs.avs_waitrequest) begin
        done = 1'b1;
        data = avs.avs_readdata;
      end else begin
        waits++;
      end
      tick();
      take_b = 1'b0;
    end
    avs.avs_read = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_waits"}, waits, exp_waits);
    check({tag, "_data"}, data, exp);
  endtask

  task automatic cpu_write(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    avs.avs_address    = a;
    avs.avs_writedata  = d;
    avs.avs_byteenable = be;
    avs.avs_write      = 1'b1;
    #3;
    check({tag, "_wait"}, {31'd0, avs.avs_waitrequest}, 32'd0);
    tick();
    avs.avs_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_a = 1'b0;
    take_b = 1'b0;
    take_no_a = 1'b0;
    avs.avs_address = '0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = '0;
    avs.avs_byteenable = 4'hF;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_mondreg", mon_dreg, 32'd0);
    check("rst_ready", {31'd0, mon_ready}, 32'd0);
    check("rst_error", {31'd0, mon_error}, 32'd0);
    check("rst_wait", {31'd0, avs.avs_waitrequest}, 32'd0);
    check("rst_readdata", avs.avs_readdata, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Write then read back with auto-increment.
    jtag_load(9'h010, 1'b1, 1'b0, 1'b0);
    jtag_write(32'hDEADBEEF);
    jtag_write(32'h12345678);
    jtag_load(9'h010, 1'b1, 1'b1, 1'b0);
    jtag_result("rb0", 32'hDEADBEEF);
    jtag_read_pulse();
    jtag_result("rb1", 32'h12345678);

    // Address wrap 0xFF -> 0x00.
    jtag_load(9'h0FF, 1'b1, 1'b0, 1'b0);
    jtag_write(32'hA5A5A5A5);
    jtag_write(32'h5A5A5A5A);
    cpu_read("wrap_cpu", 8'h00, 32'h5A5A5A5A, 1, 1'b0, 32'd0);
    cpu_read("wrap_ff", 8'hFF, 32'hA5A5A5A5, 1, 1'b0, 32'd0);
    check("wrap_error", {31'd0, mon_error}, 32'd0);

    // CPU read colliding with a JTAG write to the same word.
    jtag_load(9'h020, 1'b0, 1'b0, 1'b0);
    cpu_read("contend", 8'h20, 32'h11112222, 3, 1'b1, 32'h11112222);

    // Byte-enable write from the CPU.
    jtag_load(9'h030, 1'b0, 1'b0, 1'b0);
    jtag_write(32'h00000000);
    cpu_write("be_wr", 8'h30, 32'hFFFFFFFF, 4'b0101);
    jtag_load(9'h030, 1'b0, 1'b1, 1'b0);
    jtag_result("be", 32'h00FF00FF);

    // Out-of-range address blocks writes; clear restores.
    jtag_load(9'h040, 1'b0, 1'b0, 1'b0);
    jtag_write(32'hCAFEF00D);
    jtag_load(9'h140, 1'b0, 1'b0, 1'b0);
    check("oor_error", {31'd0, mon_error}, 32'd1);
    jtag_write(32'h0BAD0BAD);
    jtag_load(9'h040, 1'b0, 1'b1, 1'b1);
    check("clr_error", {31'd0, mon_error}, 32'd0);
    jtag_result("oor", 32'hCAFEF00D);

    // Simultaneous write + read pulses: write wins, error flagged.
    jtag_load(9'h050, 1'b0, 1'b0, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h00000077;
    take_b = 1'b1;
    take_no_a = 1'b1;
    tick();
    take_b = 1'b0;
    take_no_a = 1'b0;
    tick();
    check("simul_error", {31'd0, mon_error}, 32'd1);
    jtag_load(9'h050, 1'b0, 1'b1, 1'b1);
    jtag_result("simul", 32'h00000077);

    // Reset while in JRD.
    jtag_load(9'h010, 1'b0, 1'b1, 1'b0);
    tick();
    check("jrd_state", {30'd0, dbg_state}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_jrd_state", {30'd0, dbg_state}, 32'd0);
    check("rst_jrd_ready", {31'd0, mon_ready}, 32'd0);
    check("rst_jrd_mondreg", mon_dreg, 32'd0);
    tick();
    check("rst_jrd_ready2", {31'd0, mon_ready}, 32'd0);
    cpu_read("ram_kept", 8'h10, 32'hDEADBEEF, 1, 1'b0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
